// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture path: byte width and FSM state codes.
package la_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/la_byte_buf.sv
// Capture buffer: DEPTH x BYTE_W storage with one write port and a registered read port.
module la_byte_buf
  import la_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  // Storage carries no reset so it can map onto RAM; contents after reset are don't-care.
  logic [BYTE_W-1:0] mem [DEPTH];

  // Write port: one byte per strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds the last byte read when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/i2c_capture_ctrl.sv
// Triggered capture sequencer between the I2C byte decoder and the readout mux.
// Arms on command, waits for a trigger byte, buffers bytes until length or idle
// timeout, then lets the host drain the buffer.
module i2c_capture_ctrl
  import la_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int TIMEOUT_W = 16,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_mode,
  input  logic [BYTE_W-1:0]    trig_value,
  input  logic [BYTE_W-1:0]    trig_mask,
  input  logic [CW-1:0]        capture_len,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [BYTE_W-1:0]    dec_data,
  input  logic                 dec_valid,
  output logic                 dec_detect_only,
  input  logic                 rd_en,
  output logic [BYTE_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic [1:0]           state,
  output logic [CW-1:0]        count,
  output logic                 timed_out
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  logic [1:0]           state_reg;
  logic [CW-1:0]        count_reg;
  logic                 timed_out_reg;
  logic                 rd_valid_reg;
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        len_reg;
  logic                 mode_reg;
  logic [BYTE_W-1:0]    val_reg;
  logic [BYTE_W-1:0]    mask_reg;
  logic [TIMEOUT_W-1:0] timeout_reg;
  logic [TIMEOUT_W-1:0] idle_reg;

  logic                 arm_ok;
  logic                 trig_hit;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [CW-1:0]        len_norm;
  logic [CW-1:0]        count_inc;
  logic [TIMEOUT_W-1:0] idle_inc;
  logic                 idle_expire;

  // Qualifiers for trigger, writes, reads, length normalisation and idle timeout.
  always_comb begin
    arm_ok      = arm && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    trig_hit    = dec_valid && (!mode_reg || (((dec_data ^ val_reg) & mask_reg) == '0));
    wr_fire     = !abort && (((state_reg == ST_ARMED) && trig_hit) ||
                             ((state_reg == ST_CAPTURE) && dec_valid));
    rd_fire     = !abort && !arm_ok && (state_reg == ST_DONE) && (count_reg != '0) && rd_en;
    len_norm    = ((capture_len == '0) || (capture_len > DEPTH_CW)) ? DEPTH_CW : capture_len;
    count_inc   = count_reg + CW'(1);
    idle_inc    = (idle_reg == '1) ? idle_reg : idle_reg + TIMEOUT_W'(1);
    // Expiry is judged on the value the counter reaches this edge, so DONE lands
    // exactly 'timeout' idle cycles after the last byte.
    idle_expire = (timeout_reg != '0) && (idle_inc == timeout_reg);
  end

  // Capture FSM with count, pointers, latched configuration and idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      timed_out_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      len_reg       <= DEPTH_CW;
      mode_reg      <= 1'b0;
      val_reg       <= '0;
      mask_reg      <= '0;
      timeout_reg   <= '0;
      idle_reg      <= '0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (abort) begin
        state_reg <= ST_IDLE;
        count_reg <= '0;
      end else if (arm_ok) begin
        state_reg     <= ST_ARMED;
        count_reg     <= '0;
        timed_out_reg <= 1'b0;
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        len_reg       <= len_norm;
        mode_reg      <= trig_mode;
        val_reg       <= trig_value;
        mask_reg      <= trig_mask;
        timeout_reg   <= timeout;
        idle_reg      <= '0;
      end else begin
        case (state_reg)
          ST_ARMED: begin
            if (trig_hit) begin
              wr_ptr_reg <= wr_ptr_reg + AW'(1);
              count_reg  <= count_inc;
              idle_reg   <= '0;
              state_reg  <= (len_reg == CW'(1)) ? ST_DONE : ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (dec_valid) begin
              wr_ptr_reg <= wr_ptr_reg + AW'(1);
              count_reg  <= count_inc;
              idle_reg   <= '0;
              if (count_inc == len_reg) begin
                state_reg <= ST_DONE;
              end
            end else begin
              idle_reg <= idle_inc;
              if (idle_expire) begin
                state_reg     <= ST_DONE;
                timed_out_reg <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (rd_fire) begin
              rd_ptr_reg <= rd_ptr_reg + AW'(1);
              count_reg  <= count_reg - CW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  la_byte_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr_reg),
    .wr_data(dec_data),
    .rd_en  (rd_fire),
    .rd_addr(rd_ptr_reg),
    .rd_data(rd_data)
  );

  assign dec_detect_only = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign rd_valid        = rd_valid_reg;
  assign state           = state_reg;
  assign count           = count_reg;
  assign timed_out       = timed_out_reg;

endmodule

// File: tb/tb_i2c_capture_ctrl.sv
// Directed bench for i2c_capture_ctrl: vector tables for the plain capture and
// masked-trigger flows, hand sequences for timeout, abort, full depth and reset.
module tb_i2c_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, abort, trig_mode, dec_valid, rd_en;
  logic [7:0]  trig_value, trig_mask, dec_data;
  logic [3:0]  capture_len;
  logic [15:0] timeout;
  logic        dec_detect_only, rd_valid, timed_out;
  logic [7:0]  rd_data;
  logic [1:0]  state;
  logic [3:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  i2c_capture_ctrl #(.DEPTH(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_value(trig_value), .trig_mask(trig_mask), .capture_len(capture_len),
    .timeout(timeout), .dec_data(dec_data), .dec_valid(dec_valid),
    .dec_detect_only(dec_detect_only), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .state(state), .count(count), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arm;
    logic       abort;
    logic       dv;
    logic [7:0] d;
    logic       rden;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic a, input logic ab, input logic dv, input logic [7:0] d,
                              input logic re, input logic [1:0] st, input logic [3:0] cnt,
                              input logic rv, input logic [7:0] rdat);
    vec_t v;
    v.arm = a; v.abort = ab; v.dv = dv; v.d = d; v.rden = re;
    v.st = st; v.cnt = cnt; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock with the given pulses; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic a, input logic ab, input logic dv, input logic [7:0] d,
                     input logic re);
    arm = a; abort = ab; dec_valid = dv; dec_data = d; rd_en = re;
    @(posedge clk);
    #1;
    arm = 1'b0; abort = 1'b0; dec_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      cyc(vecs[i].arm, vecs[i].abort, vecs[i].dv, vecs[i].d, vecs[i].rden);
      chk($sformatf("%s[%0d].state", tag, i), state, vecs[i].st);
      chk($sformatf("%s[%0d].count", tag, i), count, vecs[i].cnt);
      chk($sformatf("%s[%0d].rd_valid", tag, i), rd_valid, vecs[i].rv);
      chk($sformatf("%s[%0d].detect_only", tag, i), dec_detect_only,
          (vecs[i].st == 2'd0 || vecs[i].st == 2'd3) ? 1 : 0);
      if (vecs[i].rv) chk($sformatf("%s[%0d].rd_data", tag, i), rd_data, vecs[i].rdat);
      $display("%s[%0d] st=%0d cnt=%0d rv=%0b rd=%02h", tag, i, state, count, rd_valid, rd_data);
    end
    vecs.delete();
  endtask

  task automatic set_cfg(input logic m, input logic [7:0] v, input logic [7:0] msk,
                         input logic [3:0] len, input logic [15:0] to);
    trig_mode = m; trig_value = v; trig_mask = msk; capture_len = len; timeout = to;
  endtask

  initial begin
    int k;
    rst = 1'b1; arm = 0; abort = 0; dec_valid = 0; rd_en = 0; dec_data = 0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.state", state, 0);
    chk("reset.count", count, 0);
    chk("reset.rd_valid", rd_valid, 0);
    chk("reset.rd_data", rd_data, 0);
    chk("reset.timed_out", timed_out, 0);
    chk("reset.detect_only", dec_detect_only, 1);

    // 1: trigger on any byte, length 3; fourth byte dropped, fourth read empty.
    set_cfg(0, 8'h00, 8'h00, 4'd3, 16'd0);
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2'd1, 4'd0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'hA5, 0, 2'd2, 4'd1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h3C, 0, 2'd2, 4'd2, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h7E, 0, 2'd3, 4'd3, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h11, 0, 2'd3, 4'd3, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd2, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd0, 1, 8'h7E));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd0, 0, 8'h00));
    run_vecs("t1");

    // 2: masked trigger val=50 mask=F0; 12 ignored, 5A is entry 0, 99 entry 1.
    set_cfg(1, 8'h50, 8'hF0, 4'd3, 16'd0);
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 2'd1, 4'd0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h12, 0, 2'd1, 4'd0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h5A, 0, 2'd2, 4'd1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h99, 0, 2'd2, 4'd2, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd2, 4'd2, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h77, 0, 2'd3, 4'd3, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd2, 1, 8'h5A));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd1, 1, 8'h99));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2'd3, 4'd0, 1, 8'h77));
    run_vecs("t2");

    // 3: length 4, timeout 10; DONE exactly 10 cycles after the second byte.
    set_cfg(0, 0, 0, 4'd4, 16'd10);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'hC1, 0);
    cyc(0, 0, 1, 8'hC2, 0);
    k = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 0, 0, 8'h00, 0);
      if (state == 2'd3) begin
        k = i;
        break;
      end
    end
    chk("t3.timeout_cycles", k, 10);
    chk("t3.timed_out", timed_out, 1);
    chk("t3.count", count, 2);
    $display("t3 done after %0d idle cycles timed_out=%0b count=%0d", k, timed_out, count);

    // 4: abort with arm in the same cycle mid-capture wins.
    set_cfg(0, 0, 0, 4'd4, 16'd0);
    cyc(1, 0, 0, 8'h00, 0);
    chk("t4.timed_out_cleared", timed_out, 0);
    cyc(0, 0, 1, 8'hD1, 0);
    cyc(0, 0, 1, 8'hD2, 0);
    chk("t4.count_before", count, 2);
    cyc(1, 1, 0, 8'h00, 0);
    chk("t4.state", state, 0);
    chk("t4.count", count, 0);
    chk("t4.detect_only", dec_detect_only, 1);
    $display("t4 abort st=%0d cnt=%0d det=%0b", state, count, dec_detect_only);

    // 5: length 0 means full depth; ten bytes, eight kept, then re-arm.
    set_cfg(0, 0, 0, 4'd0, 16'd0);
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 8'h10 + 8'(i), 0);
      chk($sformatf("t5.wr%0d.state", i), state, (i >= 7) ? 3 : 2);
      chk($sformatf("t5.wr%0d.count", i), count, (i >= 7) ? 8 : i + 1);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 8'h00, 1);
      chk($sformatf("t5.rd%0d.valid", i), rd_valid, 1);
      chk($sformatf("t5.rd%0d.data", i), rd_data, 8'h10 + i);
      chk($sformatf("t5.rd%0d.count", i), count, 7 - i);
      $display("t5 read %0d data=%02h cnt=%0d", i, rd_data, count);
    end
    set_cfg(0, 0, 0, 4'd3, 16'd0);
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h20 + 8'(i), 0);
    chk("t5.rearm.state", state, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 8'h00, 1);
      chk($sformatf("t5.rearm.rd%0d", i), rd_data, 8'h20 + i);
    end

    // 6: reset mid-capture clears every output; re-arm works.
    set_cfg(0, 0, 0, 4'd4, 16'd0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'hE1, 0);
    cyc(0, 0, 1, 8'hE2, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 8'h00, 0);
    rst = 1'b0;
    chk("t6.state", state, 0);
    chk("t6.count", count, 0);
    chk("t6.rd_valid", rd_valid, 0);
    chk("t6.rd_data", rd_data, 0);
    chk("t6.timed_out", timed_out, 0);
    chk("t6.detect_only", dec_detect_only, 1);
    set_cfg(0, 0, 0, 4'd2, 16'd0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h33, 0);
    cyc(0, 0, 1, 8'h44, 0);
    chk("t6.rearm.state", state, 3);
    cyc(0, 0, 0, 8'h00, 1);
    chk("t6.rearm.rd0", rd_data, 8'h33);
    cyc(0, 0, 0, 8'h00, 1);
    chk("t6.rearm.rd1", rd_data, 8'h44);
    $display("t6 reset/re-arm st=%0d cnt=%0d rd=%02h", state, count, rd_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
